// File: rtl/seq_divider_32b.sv
// seq_divider_32b
//   Multi-cycle radix-2 restoring divider for the execute stage
//   (DIV/DIVU/REM/REMU). One operation per accepted start; an operation
//   occupies 32 CALC iterations plus one FIX cycle, so done pulses 33
//   cycles after the start edge.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle (busy=0)
//   signed_op    1 = two's complement operands, 0 = unsigned
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high from the accepting edge until the done edge
//   done         one-cycle pulse, results valid
//   quotient     registered quotient, held until next done
//   remainder    registered remainder, held until next done
//   div_by_zero  registered divide-by-zero flag, held until next done
//
// Build option
//   DIV_EARLY_OUT_EN : when defined, a divide by zero or |divisor| > |dividend|
//                      skips CALC and completes one cycle after start.
//                      Results are identical with or without it.
module seq_divider_32b #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_dvs;      // |divisor|
  logic [WIDTH-1:0] r_quo;      // dividend shift register / quotient bits
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_dvd_raw;  // original dividend for dz / early results
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dz;
  logic             r_early;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic             w_dz;
  logic             w_early;
  logic             w_last;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_no_borrow;

  assign w_abs_dvd = (signed_op && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
  assign w_abs_dvs = (signed_op && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
  assign w_dz      = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_dz | (w_abs_dvs > w_abs_dvd);
`else
  assign w_early = 1'b0;
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Trial subtraction T - |divisor| as T + ~D + 1; cout=1 means no borrow.
  assign w_t    = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_sub  = {1'b0, w_t} + {1'b0, ~r_dvs} + {{WIDTH{1'b0}}, 1'b1};
  assign w_sum  = w_sub[WIDTH-1:0];
  assign w_cout = w_sub[WIDTH];
  // The bit shifted out of R is the 33rd bit of T: if set, T >= 2^WIDTH > D.
  assign w_no_borrow = r_rem[WIDTH-1] | w_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = w_early ? FIX : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_next = FIX;
        end
      end
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvs         <= '0;
      r_quo         <= '0;
      r_rem         <= '0;
      r_dvd_raw     <= '0;
      r_cnt         <= '0;
      r_qneg        <= 1'b0;
      r_rneg        <= 1'b0;
      r_dz          <= 1'b0;
      r_early       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvs     <= w_abs_dvs;
            r_quo     <= w_abs_dvd;
            r_rem     <= '0;
            r_dvd_raw <= dividend;
            r_cnt     <= '0;
            r_qneg    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_rneg    <= signed_op & dividend[WIDTH-1];
            r_dz      <= w_dz;
            r_early   <= w_early;
            r_busy    <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_no_borrow ? w_sum : w_t;
          r_quo <= {r_quo[WIDTH-2:0], w_no_borrow};
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (r_dz) begin
            r_quotient    <= '1;
            r_remainder   <= r_dvd_raw;
            r_div_by_zero <= 1'b1;
          end else if (r_early) begin
            r_quotient    <= '0;
            r_remainder   <= r_dvd_raw;
            r_div_by_zero <= 1'b0;
          end else begin
            r_quotient    <= r_qneg ? ('0 - r_quo) : r_quo;
            r_remainder   <= r_rneg ? ('0 - r_rem) : r_rem;
            r_div_by_zero <= 1'b0;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
